pwm_bank: RTL and testbench

PWM_BANK -- requirements
Module: pwm_bank

---
 rtl/pwm_bank.sv | 266 ++++++++++++++++++++++++++
 tb/tb_pwm_bank.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_bank.sv
// Bank of CHANNELS PWM generators sharing one prescaler, counter and period.
// Memory-mapped register file with shadowed PERIOD/DUTY registers that are
// copied into the active set at each period boundary, or continuously while
// the bank is disabled.
module pwm_bank #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 16,
    parameter logic [2:0]  ADDR_SEL = 3'b001
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         addr,
    input  logic [31:0]         data_in,
    input  logic                write_enable,
    output logic [31:0]         data_out,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_irq
);

    localparam logic [WIDTH-1:0] CntOne = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [5:0] OffCtrl   = 6'd0;
    localparam logic [5:0] OffPeriod = 6'd1;
    localparam logic [5:0] OffStatus = 6'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                           en_q, en_d;
    logic                           mode_q, mode_d;
    logic [7:0]                     presc_q, presc_d;

    logic [WIDTH-1:0]               period_sh_q, period_sh_d;
    logic [WIDTH-1:0]               period_act_q, period_act_d;
    logic [CHANNELS-1:0][WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic [CHANNELS-1:0][WIDTH-1:0] duty_act_q, duty_act_d;

    logic [7:0]                     presc_cnt_q, presc_cnt_d;
    logic [WIDTH-1:0]               cnt_q, cnt_d;
    logic                           dir_q, dir_d;      // 1 = counting down

    logic [31:0]                    data_out_q, data_out_d;
    logic [CHANNELS-1:0]            pwm_q, pwm_d;
    logic                           irq_q, irq_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic                sel;
    logic                wr_en;
    logic [5:0]          off;
    logic                wr_ctrl;
    logic                wr_period;
    logic [CHANNELS-1:0] wr_duty;

    assign sel       = (addr[31:29] == ADDR_SEL);
    assign wr_en     = sel && write_enable;
    assign off       = addr[7:2];
    assign wr_ctrl   = wr_en && (off == OffCtrl);
    assign wr_period = wr_en && (off == OffPeriod);

    // Only the select field and word offset of the address are decoded.
    logic unused_bits;
    assign unused_bits = ^{addr[28:8], addr[1:0], data_in};

    // Per-channel DUTY write strobes; channels beyond CHANNELS never match.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            wr_duty[i] = wr_en && (off == 6'(4 + i));
        end
    end

    // ------------------------------------------------------------------
    // Control register next state
    // ------------------------------------------------------------------
    logic mode_chg;

    // CTRL write applies on the next edge; a MODE flip while running restarts the count.
    always_comb begin
        en_d    = en_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        if (wr_ctrl) begin
            en_d    = data_in[0];
            mode_d  = data_in[1];
            presc_d = data_in[15:8];
        end
    end

    assign mode_chg = en_q && (mode_d != mode_q);

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic tick;

    // '>=' keeps the prescaler from running away if PRESC is lowered mid-count.
    assign tick = en_q && (presc_cnt_q >= presc_q);

    // Prescaler counter: free-runs while enabled, held at 0 otherwise.
    always_comb begin
        presc_cnt_d = presc_cnt_q + 8'd1;
        if (!en_q || !en_d || tick) begin
            presc_cnt_d = 8'd0;
        end
    end

    // ------------------------------------------------------------------
    // Period counter
    // ------------------------------------------------------------------
    logic bnd;

    // Counter advance on each tick for edge and center modes; flags the period boundary.
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        bnd   = 1'b0;
        if (tick) begin
            if (!mode_q) begin
                if (cnt_q >= period_act_q) begin
                    cnt_d = '0;
                    bnd   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end else if (!dir_q) begin
                if (cnt_q >= period_act_q) begin
                    // At the top: turn around; PERIOD of 0 or 1 lands straight on 0.
                    if (cnt_q <= CntOne) begin
                        cnt_d = '0;
                        dir_d = 1'b0;
                        bnd   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                        dir_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end else begin
                if (cnt_q <= CntOne) begin
                    cnt_d = '0;
                    dir_d = 1'b0;
                    bnd   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
        end
        if (!en_d || mode_chg) begin
            cnt_d = '0;
            dir_d = 1'b0;
            bnd   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Shadow and active PERIOD/DUTY
    // ------------------------------------------------------------------
    logic load;

    // Loading from the shadow next-state makes a write coincident with a boundary land directly.
    assign load = !en_q || bnd;

    // Shadow registers take bus writes; active copies follow them on load.
    always_comb begin
        period_sh_d = period_sh_q;
        if (wr_period) begin
            period_sh_d = data_in[WIDTH-1:0];
        end
        period_act_d = load ? period_sh_d : period_act_q;

        duty_sh_d  = duty_sh_q;
        duty_act_d = duty_act_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_duty[i]) begin
                duty_sh_d[i] = data_in[WIDTH-1:0];
            end
            if (load) begin
                duty_act_d[i] = duty_sh_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic pending;

    assign pending = (period_sh_q != period_act_q) || (duty_sh_q != duty_act_q);

    // PWM compare lags the counter by one cycle; forced low while or when disabling.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = en_q && en_d && (cnt_q < duty_act_q[i]);
        end
        irq_d = bnd;
    end

    // Readback mux; unselected, unmapped and out-of-range DUTY read as zero.
    always_comb begin
        data_out_d = '0;
        if (sel) begin
            case (off)
                OffCtrl: begin
                    data_out_d[0]    = en_q;
                    data_out_d[1]    = mode_q;
                    data_out_d[15:8] = presc_q;
                end
                OffPeriod: begin
                    data_out_d[WIDTH-1:0] = period_sh_q;
                end
                OffStatus: begin
                    data_out_d[WIDTH-1:0] = cnt_q;
                    data_out_d[16]        = dir_q;
                    data_out_d[17]        = pending;
                end
                default: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (off == 6'(4 + i)) begin
                            data_out_d[WIDTH-1:0] = duty_sh_q[i];
                        end
                    end
                end
            endcase
        end
    end

    // State register with synchronous active-low reset taking priority over writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q         <= 1'b0;
            mode_q       <= 1'b0;
            presc_q      <= '0;
            period_sh_q  <= '0;
            period_act_q <= '0;
            duty_sh_q    <= '0;
            duty_act_q   <= '0;
            presc_cnt_q  <= '0;
            cnt_q        <= '0;
            dir_q        <= 1'b0;
            data_out_q   <= '0;
            pwm_q        <= '0;
            irq_q        <= 1'b0;
        end else begin
            en_q         <= en_d;
            mode_q       <= mode_d;
            presc_q      <= presc_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            duty_sh_q    <= duty_sh_d;
            duty_act_q   <= duty_act_d;
            presc_cnt_q  <= presc_cnt_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            data_out_q   <= data_out_d;
            pwm_q        <= pwm_d;
            irq_q        <= irq_d;
        end
    end

    assign data_out   = data_out_q;
    assign pwm_out    = pwm_q;
    assign period_irq = irq_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: register map table plus hand-computed
// cycle sequences for edge, center, shadow, boundary, prescaler and reset.
module tb_pwm_bank;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        write_enable;
    logic [31:0] data_out;
    logic [3:0]  pwm_out;
    logic        period_irq;

    int n_cmp;
    int n_bad;

    pwm_bank #(
        .CHANNELS(4),
        .WIDTH   (16),
        .ADDR_SEL(3'b001)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .data_in     (data_in),
        .write_enable(write_enable),
        .data_out    (data_out),
        .pwm_out     (pwm_out),
        .period_irq  (period_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        sel;
        logic        wr;
        logic [5:0]  off;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic we, input logic [5:0] off,
                         input logic [31:0] d);
        addr         = {(s ? 3'b001 : 3'b110), 21'd0, off, 2'b00};
        write_enable = we;
        data_in      = d;
    endtask

    // Starts and ends on a falling edge.
    task automatic wr(input logic [5:0] off, input logic [31:0] d);
        drive(1'b1, 1'b1, off, d);
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    function automatic int tri_wave(input int j);
        return (j <= 4) ? j : 8 - j;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0]  exp_pwm;
        logic [31:0] exp_st;
        logic        prev_st;
        int          d;
        int          j;
        logic [5:0]  offs [7];

        n_cmp = 0;
        n_bad = 0;

        tbl[0]  = '{1'b1, 1'b1, 6'd1,  32'h0001_2345, 32'h0000_2345};
        tbl[1]  = '{1'b0, 1'b1, 6'd1,  32'h0000_0055, 32'h0000_0000};
        tbl[2]  = '{1'b1, 1'b0, 6'd1,  32'h0000_0000, 32'h0000_2345};
        tbl[3]  = '{1'b1, 1'b1, 6'd4,  32'h0000_AAAA, 32'h0000_AAAA};
        tbl[4]  = '{1'b1, 1'b1, 6'd7,  32'h0000_0005, 32'h0000_0005};
        tbl[5]  = '{1'b1, 1'b1, 6'd8,  32'h0000_0077, 32'h0000_0000};
        tbl[6]  = '{1'b1, 1'b1, 6'd3,  32'h0000_FFFF, 32'h0000_0000};
        tbl[7]  = '{1'b1, 1'b1, 6'd0,  32'hFFFF_FF02, 32'h0000_FF02};
        tbl[8]  = '{1'b1, 1'b1, 6'd2,  32'h0000_FFFF, 32'h0000_0000};
        tbl[9]  = '{1'b1, 1'b1, 6'd0,  32'h0000_0000, 32'h0000_0000};
        tbl[10] = '{1'b1, 1'b1, 6'd63, 32'h0000_1234, 32'h0000_0000};
        tbl[11] = '{1'b1, 1'b0, 6'd5,  32'h0000_0000, 32'h0000_0000};

        // Reset
        rst = 1'b0;
        drive(1'b1, 1'b0, 6'd0, 32'd0);
        repeat (3) @(negedge clk);
        check("reset pwm_out", 32'(pwm_out), 32'd0);
        check("reset period_irq", 32'(period_irq), 32'd0);
        check("reset data_out", data_out, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Register map
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].wr) begin
                drive(tbl[i].sel, 1'b1, tbl[i].off, tbl[i].wdata);
                @(negedge clk);
            end
            drive(tbl[i].sel, 1'b0, tbl[i].off, 32'd0);
            @(negedge clk);
            check($sformatf("regmap[%0d]", i), data_out, tbl[i].exp);
        end

        // Edge mode, PERIOD=9 DUTY0=3, shadow update at k=34, boundary-coincident write at k=50
        wr(6'd1, 32'd9);
        wr(6'd4, 32'd3);
        wr(6'd5, 32'd0);
        wr(6'd6, 32'd0);
        wr(6'd7, 32'd12);
        wr(6'd0, 32'h1);
        prev_st = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            d = (k >= 52) ? 5 : ((k >= 42) ? 7 : 3);
            exp_pwm = {(k >= 2), 1'b0, 1'b0, (k >= 2) && (((k - 2) % 10) < d)};
            check($sformatf("edge pwm k=%0d", k), 32'(pwm_out), 32'(exp_pwm));
            check($sformatf("edge irq k=%0d", k), 32'(period_irq),
                  32'((k >= 11) && (((k - 11) % 10) == 0)));
            if (prev_st) begin
                exp_st     = 32'((k - 2) % 10);
                exp_st[17] = (k >= 36) && (k <= 41);
                check($sformatf("edge status k=%0d", k), data_out, exp_st);
            end
            if (k == 34) begin
                drive(1'b1, 1'b1, 6'd4, 32'd7);
                prev_st = 1'b0;
            end else if (k == 50) begin
                drive(1'b1, 1'b1, 6'd4, 32'd5);
                prev_st = 1'b0;
            end else begin
                drive(1'b1, 1'b0, 6'd2, 32'd0);
                prev_st = 1'b1;
            end
            @(negedge clk);
        end

        // Disable: outputs drop on the very next cycle
        wr(6'd0, 32'h0);
        check("disable pwm_out", 32'(pwm_out), 32'd0);
        check("disable period_irq", 32'(period_irq), 32'd0);

        // Center mode, PERIOD=4 DUTY1=2
        wr(6'd1, 32'd4);
        wr(6'd5, 32'd2);
        wr(6'd0, 32'h3);
        prev_st = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            j = (k - 2) % 8;
            exp_pwm = (k >= 2) ? {1'b1, 1'b0, (tri_wave(j) < 2), 1'b1} : 4'b0000;
            check($sformatf("center pwm k=%0d", k), 32'(pwm_out), 32'(exp_pwm));
            check($sformatf("center irq k=%0d", k), 32'(period_irq),
                  32'((k > 1) && (((k - 1) % 8) == 0)));
            if (prev_st) begin
                exp_st     = 32'(tri_wave(j));
                exp_st[16] = (j >= 5);
                check($sformatf("center status k=%0d", k), data_out, exp_st);
            end
            drive(1'b1, 1'b0, 6'd2, 32'd0);
            prev_st = 1'b1;
            @(negedge clk);
        end

        // MODE change while counting down: counter and direction restart
        wr(6'd0, 32'h1);
        drive(1'b1, 1'b0, 6'd2, 32'd0);
        @(negedge clk);
        check("mode change status", data_out, 32'd0);

        // PERIOD=0: boundary on every tick
        wr(6'd0, 32'h0);
        wr(6'd1, 32'd0);
        wr(6'd0, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            exp_pwm = (k >= 2) ? 4'b1011 : 4'b0000;
            check($sformatf("p0 pwm k=%0d", k), 32'(pwm_out), 32'(exp_pwm));
            check($sformatf("p0 irq k=%0d", k), 32'(period_irq), 32'(k >= 2));
            @(negedge clk);
        end

        // PRESC=3, PERIOD=1
        wr(6'd0, 32'h0);
        wr(6'd1, 32'd1);
        wr(6'd0, 32'h0301);
        prev_st = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            exp_pwm = (k >= 2) ? 4'b1011 : 4'b0000;
            check($sformatf("presc pwm k=%0d", k), 32'(pwm_out), 32'(exp_pwm));
            check($sformatf("presc irq k=%0d", k), 32'(period_irq),
                  32'((k > 1) && (((k - 1) % 8) == 0)));
            if (prev_st) begin
                check($sformatf("presc status k=%0d", k), data_out,
                      32'(((k - 2) / 4) % 2));
            end
            drive(1'b1, 1'b0, 6'd2, 32'd0);
            prev_st = 1'b1;
            @(negedge clk);
        end

        // Reset mid-period with a concurrent write
        rst = 1'b0;
        drive(1'b1, 1'b1, 6'd4, 32'h99);
        @(negedge clk);
        check("rst pwm_out", 32'(pwm_out), 32'd0);
        check("rst period_irq", 32'(period_irq), 32'd0);
        check("rst data_out", data_out, 32'd0);
        rst = 1'b1;
        write_enable = 1'b0;
        offs = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd5, 6'd6, 6'd7};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, offs[i], 32'd0);
            @(negedge clk);
            check($sformatf("post-rst reg off=%0d", offs[i]), data_out, 32'd0);
        end
        check("post-rst pwm_out", 32'(pwm_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
